rom_arbiter: RTL

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter_if.sv | 31 +++
 rtl/rom_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/rom_arbiter_if.sv
// Two-port ROM read bus between the requesters/ROM and rom_arbiter.
// The master side drives requests and ROM data; the slave side is the arbiter.
interface rom_arbiter_if #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 8
);
   logic                  req0;
   logic [ADDR_WIDTH-1:0] addr0;
   logic                  req1;
   logic [ADDR_WIDTH-1:0] addr1;
   logic                  grant0;
   logic                  grant1;
   logic                  valid0;
   logic                  valid1;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  busy;
   logic [ADDR_WIDTH-1:0] rom_address;
   logic [DATA_WIDTH-1:0] rom_data;

   modport master (
      output req0, addr0, req1, addr1, rom_data,
      input  grant0, grant1, valid0, valid1,
      input  data_out, busy, rom_address
   );

   modport slave (
      input  req0, addr0, req1, addr1, rom_data,
      output grant0, grant1, valid0, valid1,
      output data_out, busy, rom_address
   );
endinterface

// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of a synchronous ROM, one access per 2 cycles.
// Define ROM_ARB_RR_EN for round-robin ties; default is port 0 fixed priority.
module rom_arbiter #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 8
) (
   input logic          raw_clk,
   input logic          reset,
   rom_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic                  grant0_q, grant0_d;
   logic                  grant1_q, grant1_d;
   logic                  valid0_q, valid0_d;
   logic                  valid1_q, valid1_d;
   logic                  owner_q, owner_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  any_req;
   logic                  arb_pt;
   logic                  win1;

`ifdef ROM_ARB_RR_EN
   // last_q = 1 means port 1 was served most recently
   logic                  last_q, last_d;
`endif

   assign any_req = bus.req0 | bus.req1;
   assign arb_pt  = (state_q == IDLE) || (state_q == RESP);

`ifdef ROM_ARB_RR_EN
   assign win1 = bus.req1 & (~bus.req0 | ~last_q);
`else
   assign win1 = bus.req1 & ~bus.req0;
`endif

   always_ff @(posedge raw_clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    state_d = any_req ? READ : IDLE;
         READ:    state_d = RESP;
         RESP:    state_d = any_req ? READ : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant0_d = 1'b0;
      grant1_d = 1'b0;
      valid0_d = 1'b0;
      valid1_d = 1'b0;
      owner_d  = owner_q;
      addr_d   = addr_q;
      data_d   = data_q;
`ifdef ROM_ARB_RR_EN
      last_d   = last_q;
`endif
      if (arb_pt && any_req) begin
         grant0_d = ~win1;
         grant1_d = win1;
         owner_d  = win1;
         addr_d   = win1 ? bus.addr1 : bus.addr0;
`ifdef ROM_ARB_RR_EN
         last_d   = win1;
`endif
      end
      if (state_q == RESP) begin
         data_d   = bus.rom_data;
         valid0_d = ~owner_q;
         valid1_d = owner_q;
      end
   end

   always_ff @(posedge raw_clk) begin
      if (reset) begin
         grant0_q <= 1'b0;
         grant1_q <= 1'b0;
         valid0_q <= 1'b0;
         valid1_q <= 1'b0;
         owner_q  <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
`ifdef ROM_ARB_RR_EN
         last_q   <= 1'b1;
`endif
      end else begin
         grant0_q <= grant0_d;
         grant1_q <= grant1_d;
         valid0_q <= valid0_d;
         valid1_q <= valid1_d;
         owner_q  <= owner_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
`ifdef ROM_ARB_RR_EN
         last_q   <= last_d;
`endif
      end
   end

   assign bus.grant0      = grant0_q;
   assign bus.grant1      = grant1_q;
   assign bus.valid0      = valid0_q;
   assign bus.valid1      = valid1_q;
   assign bus.data_out    = data_q;
   assign bus.rom_address = addr_q;
   assign bus.busy        = (state_q != IDLE);
endmodule
